cfg_mgmt_req_sequencer: RTL and testbench

//  Synthesizable front end for the PCIe core cfg_mgmt port. Sits between the RP/EP user

---
 rtl/cfg_mgmt_seq_pkg.sv | 14 +
 rtl/cfg_mgmt_req_fifo.sv | 35 +++
 rtl/cfg_mgmt_req_sequencer.sv | 122 ++++++++++++
 tb/tb_cfg_mgmt_req_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cfg_mgmt_seq_pkg.sv
// cfg_mgmt_seq_pkg: shared types and constants for the cfg_mgmt request sequencer
package cfg_mgmt_seq_pkg;
  localparam int CFG_ADDR_W = 10;
  localparam int CFG_DATA_W = 32;
  localparam logic [CFG_DATA_W-1:0] CFG_TIMEOUT_DATA = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP, GAP} state_t;
  typedef struct packed {
    logic                  write;
    logic                  type1;
    logic [3:0]            be;
    logic [CFG_ADDR_W-1:0] addr;
    logic [CFG_DATA_W-1:0] data;
  } cfg_req_t;
endpackage

// File: rtl/cfg_mgmt_req_fifo.sv
// cfg_mgmt_req_fifo: synchronous request queue with full/empty flags
module cfg_mgmt_req_fifo
  import cfg_mgmt_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  cfg_req_t data_i,
  input  logic     pop_i,
  output cfg_req_t data_o,
  output logic     full_o,
  output logic     empty_o
);
  localparam int AW = $clog2(DEPTH);
  cfg_req_t mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i && !full_o) wr_q <= wr_q + (AW+1)'(1);
      if (pop_i && !empty_o) rd_q <= rd_q + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= data_i;
  end
  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = wr_q == rd_q;
  assign data_o  = mem_q[rd_q[AW-1:0]];
endmodule

// File: rtl/cfg_mgmt_req_sequencer.sv
// cfg_mgmt_req_sequencer: queues user config requests and issues them one at a time
// on the PCIe core cfg_mgmt port, returning one response per request.
module cfg_mgmt_req_sequencer
  import cfg_mgmt_seq_pkg::*;
#(
  parameter int ADDR_W         = CFG_ADDR_W,
  parameter int DATA_W         = CFG_DATA_W,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              user_clk,
  input  logic              user_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [3:0]        req_be,
  input  logic              req_type1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_write,
  output logic              rsp_timeout,
  output logic              busy,
  output logic [ADDR_W-1:0] cfg_mgmt_addr,
  output logic              cfg_mgmt_write,
  output logic              cfg_mgmt_read,
  output logic [DATA_W-1:0] cfg_mgmt_write_data,
  output logic [3:0]        cfg_mgmt_byte_enable,
  output logic              cfg_mgmt_type1_cfg_reg_access,
  input  logic [DATA_W-1:0] cfg_mgmt_read_data,
  input  logic              cfg_mgmt_read_write_done
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t      state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  cfg_req_t    cur_q, cur_d, req_in, fifo_out;
  logic        rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d, rsp_timeout_q, rsp_timeout_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic        fifo_full, fifo_empty, pop, issue, done;
  assign req_in = '{write: req_write, type1: req_type1, be: req_be, addr: req_addr, data: req_data};
  cfg_mgmt_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (user_clk),
    .rst_i   (user_reset),
    .push_i  (req_valid && req_ready),
    .data_i  (req_in),
    .pop_i   (pop),
    .data_o  (fifo_out),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );
  assign issue = state_q == ISSUE;
  assign done  = cfg_mgmt_read_write_done;
  assign pop   = (state_q == IDLE) && !fifo_empty;
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    cur_d         = cur_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_write_d   = rsp_write_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      IDLE: if (pop) begin
        state_d = ISSUE;
        timer_d = '0;
        cur_d   = fifo_out;
        cur_d.be   = fifo_out.write ? fifo_out.be : 4'h0;
        cur_d.data = fifo_out.write ? fifo_out.data : '0;
      end
      ISSUE: begin
        timer_d = timer_q + TW'(1);
        // Done takes priority over a timeout expiring in the same cycle.
        if (done || timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d       = RESP;
          rsp_valid_d   = 1'b1;
          rsp_write_d   = cur_q.write;
          rsp_timeout_d = !done;
          rsp_data_d    = !done ? CFG_TIMEOUT_DATA : cur_q.write ? '0 : cfg_mgmt_read_data;
        end
      end
      RESP: if (rsp_ready) begin
        state_d     = GAP;
        rsp_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      cur_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_write_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      cur_q         <= cur_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_write_q   <= rsp_write_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
  // Strobes and access fields are gated by ISSUE so they drop with the state register.
  assign cfg_mgmt_write                = issue && cur_q.write;
  assign cfg_mgmt_read                 = issue && !cur_q.write;
  assign cfg_mgmt_addr                 = issue ? cur_q.addr : '0;
  assign cfg_mgmt_write_data           = issue ? cur_q.data : '0;
  assign cfg_mgmt_byte_enable          = issue ? cur_q.be : 4'h0;
  assign cfg_mgmt_type1_cfg_reg_access = issue && cur_q.type1;
  assign req_ready   = !fifo_full;
  assign busy        = !fifo_empty || (state_q != IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_write   = rsp_write_q;
  assign rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_cfg_mgmt_req_sequencer.sv
// tb_cfg_mgmt_req_sequencer: directed stimulus checked against a queue-based reference model
module tb_cfg_mgmt_req_sequencer;
  localparam int AW = 10, DW = 32, DEPTH = 4, TO = 16;
  logic user_clk = 0, user_reset = 1;
  logic req_valid = 0, req_write = 0, req_type1 = 0, rsp_ready = 1;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic [3:0] req_be = '0;
  logic req_ready, rsp_valid, rsp_write, rsp_timeout, busy;
  logic [DW-1:0] rsp_data, cfg_mgmt_write_data;
  logic [AW-1:0] cfg_mgmt_addr;
  logic cfg_mgmt_write, cfg_mgmt_read, cfg_mgmt_type1_cfg_reg_access;
  logic [3:0] cfg_mgmt_byte_enable;
  logic [DW-1:0] cfg_mgmt_read_data = '0;
  logic cfg_mgmt_read_write_done = 0;
  int n_chk = 0, n_fail = 0;
  always #5 user_clk = ~user_clk;
  cfg_mgmt_req_sequencer #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .user_clk(user_clk), .user_reset(user_reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .req_data(req_data), .req_be(req_be), .req_type1(req_type1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_write(rsp_write),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .cfg_mgmt_addr(cfg_mgmt_addr), .cfg_mgmt_write(cfg_mgmt_write), .cfg_mgmt_read(cfg_mgmt_read),
    .cfg_mgmt_write_data(cfg_mgmt_write_data), .cfg_mgmt_byte_enable(cfg_mgmt_byte_enable),
    .cfg_mgmt_type1_cfg_reg_access(cfg_mgmt_type1_cfg_reg_access),
    .cfg_mgmt_read_data(cfg_mgmt_read_data), .cfg_mgmt_read_write_done(cfg_mgmt_read_write_done)
  );
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Core responder: done arrives in the (done_after+1)-th strobe cycle; -1 never answers.
  int done_after = 3, icnt = 0;
  bit stray = 0;
  always @(negedge user_clk) begin
    if (cfg_mgmt_read || cfg_mgmt_write) begin
      cfg_mgmt_read_write_done = (icnt == done_after);
      icnt++;
    end else begin
      cfg_mgmt_read_write_done = stray;
      icnt = 0;
    end
  end
  // Reference model: pending queue, one outstanding access, one pending response, one gap cycle.
  typedef struct {bit w; bit t1; bit [3:0] be; bit [AW-1:0] a; bit [DW-1:0] d;} mreq_t;
  mreq_t fq[$];
  mreq_t cur, nr;
  bit act = 0, rp = 0, gap = 0, r_w = 0, r_to = 0, do_push, stb, prev_stb = 0;
  int acyc = 0, strobe_cyc = 0, low_run = 0, last_gap = 0;
  bit [DW-1:0] r_data = 0;
  logic [AW-1:0] iss_addr[$];
  always @(negedge user_clk) begin
    #2;
    if (user_reset) begin
      fq.delete(); act = 0; rp = 0; gap = 0; prev_stb = 0;
      chk("rst_read", cfg_mgmt_read, 0);
      chk("rst_write", cfg_mgmt_write, 0);
      chk("rst_addr", cfg_mgmt_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_ready", req_ready, 1);
    end else begin
      chk("ready", req_ready, fq.size() < DEPTH);
      chk("busy", busy, (fq.size() != 0) || act || rp || gap);
      chk("rd_stb", cfg_mgmt_read, act && !cur.w);
      chk("wr_stb", cfg_mgmt_write, act && cur.w);
      chk("addr", cfg_mgmt_addr, act ? cur.a : 0);
      chk("wdata", cfg_mgmt_write_data, (act && cur.w) ? cur.d : 0);
      chk("be", cfg_mgmt_byte_enable, (act && cur.w) ? cur.be : 0);
      chk("type1", cfg_mgmt_type1_cfg_reg_access, act && cur.t1);
      chk("rsp_valid", rsp_valid, rp);
      if (rp) begin
        chk("rsp_data", rsp_data, r_data);
        chk("rsp_write", rsp_write, r_w);
        chk("rsp_timeout", rsp_timeout, r_to);
      end
      stb = cfg_mgmt_read || cfg_mgmt_write;
      if (stb) begin
        strobe_cyc++;
        if (!prev_stb) begin iss_addr.push_back(cfg_mgmt_addr); last_gap = low_run; end
        low_run = 0;
      end else low_run++;
      prev_stb = stb;
      do_push = req_valid && (fq.size() < DEPTH);
      nr = '{w: req_write, t1: req_type1, be: req_be, a: req_addr, d: req_data};
      if (act) begin
        if (cfg_mgmt_read_write_done || acyc == TO - 1) begin
          r_to = !cfg_mgmt_read_write_done;
          r_w = cur.w;
          r_data = r_to ? '1 : cur.w ? '0 : cfg_mgmt_read_data;
          act = 0; rp = 1;
        end else acyc++;
      end else if (rp) begin
        if (rsp_ready) begin rp = 0; gap = 1; end
      end else if (gap) gap = 0;
      else if (fq.size() != 0) begin
        cur = fq.pop_front();
        if (!cur.w) begin cur.be = 0; cur.d = 0; end
        act = 1; acyc = 0;
      end
      if (do_push) fq.push_back(nr);
    end
  end
  task automatic push(bit w, bit [AW-1:0] a, bit [DW-1:0] d, bit [3:0] be, bit t1);
    req_valid = 1; req_write = w; req_addr = a; req_data = d; req_be = be; req_type1 = t1;
    for (int i = 0; i < 300 && !req_ready; i++) @(negedge user_clk);
    chk("push_accept", req_ready, 1);
    @(negedge user_clk);
    req_valid = 0;
  endtask
  task automatic wait_rsp(output logic [DW-1:0] d, output logic w, output logic to);
    for (int i = 0; i < 400 && !rsp_valid; i++) @(negedge user_clk);
    chk("rsp_seen", rsp_valid, 1);
    d = rsp_data; w = rsp_write; to = rsp_timeout;
    @(negedge user_clk);
  endtask
  logic [DW-1:0] d;
  logic w, to;
  int s0, base;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge user_clk);
    user_reset = 0;
    // 1: single read
    done_after = 3; cfg_mgmt_read_data = 32'h1234_10EE; s0 = strobe_cyc;
    push(0, 10'h004, 32'hDEAD_BEEF, 4'hF, 0);
    wait_rsp(d, w, to);
    chk("t1_data", d, 32'h1234_10EE);
    chk("t1_write", w, 0);
    chk("t1_timeout", to, 0);
    chk("t1_read_cycles", strobe_cyc - s0, 4);
    repeat (4) @(negedge user_clk);
    chk("t1_one_rsp", rsp_valid, 0);
    // 2: two writes, second queued behind the first
    done_after = 2;
    push(1, 10'h001, 32'h0000_0007, 4'h3, 0);
    push(1, 10'h002, 32'h0000_0055, 4'hF, 1);
    wait_rsp(d, w, to);
    chk("t2_data", d, 0);
    chk("t2_write", w, 1);
    wait_rsp(d, w, to);
    chk("t2b_write", w, 1);
    chk("t2_gap", last_gap, 3);
    // 3: five reads back-to-back against a slow core
    done_after = 10; base = iss_addr.size();
    for (int i = 0; i < 5; i++) push(0, 10'h010 + 10'(i), 32'h0, 4'hF, 0);
    chk("t3_full", req_ready, 0);
    for (int i = 0; i < 5; i++) begin
      wait_rsp(d, w, to);
      chk("t3_timeout", to, 0);
    end
    chk("t3_count", iss_addr.size() - base, 5);
    for (int i = 0; i < 5 && base + i < iss_addr.size(); i++)
      chk("t3_order", iss_addr[base+i], 10'h010 + 10'(i));
    // 4: timeout, then done on the final allowed cycle
    done_after = -1; s0 = strobe_cyc;
    push(0, 10'h020, 32'h0, 4'h0, 0);
    wait_rsp(d, w, to);
    chk("t4_timeout", to, 1);
    chk("t4_data", d, 32'hFFFF_FFFF);
    chk("t4_cycles", strobe_cyc - s0, 16);
    done_after = 15; s0 = strobe_cyc;
    push(0, 10'h021, 32'h0, 4'h0, 0);
    wait_rsp(d, w, to);
    chk("t4b_timeout", to, 0);
    chk("t4b_data", d, 32'h1234_10EE);
    chk("t4b_cycles", strobe_cyc - s0, 16);
    // 5: response back-pressure with stray done pulses
    done_after = 1; cfg_mgmt_read_data = 32'hA5A5_0001; rsp_ready = 0;
    push(0, 10'h030, 32'h0, 4'h0, 0);
    push(0, 10'h031, 32'h0, 4'h0, 0);
    wait_rsp(d, w, to);
    s0 = strobe_cyc;
    for (int i = 0; i < 10; i++) begin
      stray = (i % 3 == 0);
      @(negedge user_clk);
      chk("t5_hold_valid", rsp_valid, 1);
      chk("t5_hold_data", rsp_data, 32'hA5A5_0001);
    end
    stray = 0;
    chk("t5_no_issue", strobe_cyc - s0, 0);
    rsp_ready = 1;
    wait_rsp(d, w, to);
    wait_rsp(d, w, to);
    chk("t5b_data", d, 32'hA5A5_0001);
    stray = 1; repeat (3) @(negedge user_clk); stray = 0;
    chk("t5_idle_busy", busy, 0);
    // 6: reset in the middle of an access
    done_after = -1;
    push(0, 10'h040, 32'h0, 4'h0, 0);
    push(0, 10'h041, 32'h0, 4'h0, 0);
    push(0, 10'h042, 32'h0, 4'h0, 0);
    for (int i = 0; i < 50 && !cfg_mgmt_read; i++) @(negedge user_clk);
    chk("t6_issuing", cfg_mgmt_read, 1);
    @(posedge user_clk); #1 user_reset = 1; #1;
    chk("t6_strobe", cfg_mgmt_read, 0);
    chk("t6_busy", busy, 0);
    chk("t6_rsp", rsp_valid, 0);
    repeat (2) @(negedge user_clk);
    user_reset = 0;
    done_after = 2; cfg_mgmt_read_data = 32'hCAFE_0042;
    push(0, 10'h050, 32'h0, 4'h0, 0);
    wait_rsp(d, w, to);
    chk("t6_data", d, 32'hCAFE_0042);
    chk("t6_timeout", to, 0);
    repeat (4) @(negedge user_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
